// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - word-organised data memory with valid/ready request and response channels
// Optional power-up clear sweep is enabled by defining DATMEM_INIT_CLEAR_EN.
module data_mem_ctrl #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int ALENGTH = 128
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  ReqVal,
  output logic                  ReqRdy,
  input  logic                  WE2,
  input  logic [AWIDTH-1:0]     Addr,
  input  logic [DWIDTH-1:0]     WriDat,
  input  logic [DWIDTH/8-1:0]   ByteEn,
  output logic                  RspVal,
  input  logic                  RspRdy,
  output logic [DWIDTH-1:0]     ReaDat,
  output logic                  Err
);

  localparam int NB   = DWIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IW   = (ALENGTH > 1) ? $clog2(ALENGTH) : 1;

  localparam logic [0:0] RUN = 1'b1;

  logic [0:0]        state;
  logic [DWIDTH-1:0] mem [ALENGTH];
  logic [AWIDTH-1:0] word_idx;
  logic [IW-1:0]     mem_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic              accept;

  assign word_idx     = Addr >> OFFW;
  assign mem_idx      = word_idx[IW-1:0];
  assign misaligned   = |(Addr & AWIDTH'((64'd1 << OFFW) - 64'd1));
  assign out_of_range = word_idx >= AWIDTH'(ALENGTH);
  assign req_err      = misaligned | out_of_range;

  // A stalled response blocks new requests; a retiring one lets the next in on the same edge.
  assign ReqRdy = !Rst && (state == RUN) && !(RspVal && !RspRdy);
  assign accept = ReqVal && ReqRdy;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      RspVal <= 1'b0;
      Err    <= 1'b0;
      ReaDat <= '0;
    end else if (accept) begin
      RspVal <= 1'b1;
      Err    <= req_err;
      ReaDat <= (!req_err && !WE2) ? mem[mem_idx] : '0;
    end else if (RspRdy) begin
      RspVal <= 1'b0;
    end
  end

`ifdef DATMEM_INIT_CLEAR_EN
  localparam logic [0:0] CLEAR = 1'b0;

  logic [IW-1:0] clr_idx;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + IW'(1);
      if (clr_idx == IW'(ALENGTH - 1)) begin
        state <= RUN;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (state == CLEAR) begin
      if (!Rst) begin
        mem[clr_idx] <= '0;
      end
    end else if (accept && WE2 && !req_err) begin
      for (int b = 0; b < NB; b++) begin
        if (ByteEn[b]) begin
          mem[mem_idx][8*b +: 8] <= WriDat[8*b +: 8];
        end
      end
    end
  end
`else
  // Without the sweep the controller is always running and memory survives reset.
  assign state = RUN;

  always_ff @(posedge Clk) begin
    if (accept && WE2 && !req_err) begin
      for (int b = 0; b < NB; b++) begin
        if (ByteEn[b]) begin
          mem[mem_idx][8*b +: 8] <= WriDat[8*b +: 8];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl (directed scenarios plus randomized scoreboard)
module tb_data_mem_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        ReqVal = 1'b0;
  logic        WE2 = 1'b0;
  logic        RspRdy = 1'b1;
  logic [31:0] Addr = 32'h0;
  logic [31:0] WriDat = 32'h0;
  logic [3:0]  ByteEn = 4'h0;
  logic        ReqRdy;
  logic        RspVal;
  logic        Err;
  logic [31:0] ReaDat;

  int total = 0;
  int bad = 0;

`ifdef DATMEM_INIT_CLEAR_EN
  localparam int          CLR_CYC = 128;
  localparam logic [31:0] EXP_7C  = 32'h0;
`else
  localparam int          CLR_CYC = 0;
  localparam logic [31:0] EXP_7C  = 32'h5;
`endif

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
    logic [31:0] mask;
  } rsp_t;

  always #5 Clk = ~Clk;

  data_mem_ctrl #(.AWIDTH(32), .DWIDTH(32), .ALENGTH(128)) dut (
    .Clk(Clk), .Rst(Rst), .ReqVal(ReqVal), .ReqRdy(ReqRdy), .WE2(WE2),
    .Addr(Addr), .WriDat(WriDat), .ByteEn(ByteEn), .RspVal(RspVal),
    .RspRdy(RspRdy), .ReaDat(ReaDat), .Err(Err)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    ReqVal = v; WE2 = w; Addr = a; WriDat = d; ByteEn = be;
    #1;
  endtask

  task automatic test_reset;
    int n;
    Rst = 1'b1; RspRdy = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    repeat (3) begin
      tick;
      total++;
      if ({RspVal, Err, ReaDat, ReqRdy} !== 35'h0) begin
        bad++; $display("FAIL reset_outputs got=%h want=0", {RspVal, Err, ReaDat, ReqRdy});
      end
    end
    Rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    n = 0;
    while (ReqRdy !== 1'b1 && n < 400) begin tick; n++; end
    total++;
    if (n !== CLR_CYC) begin bad++; $display("FAIL reset_ready_delay got=%0d want=%0d", n, CLR_CYC); end
  endtask

  task automatic test_write_read;
    drive(1'b1, 1'b1, 32'h10, 32'h0000_6000, 4'hF);
    total++;
    if (ReqRdy !== 1'b1) begin bad++; $display("FAIL wr_ready got=%b want=1", ReqRdy); end
    tick;
    total++;
    if ({RspVal, Err, ReaDat} !== {2'b10, 32'h0}) begin
      bad++; $display("FAIL wr_rsp got=%h want=%h", {RspVal, Err, ReaDat}, {2'b10, 32'h0});
    end
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick;
    total++;
    if ({RspVal, Err, ReaDat} !== {2'b10, 32'h0000_6000}) begin
      bad++; $display("FAIL rd_after_wr got=%h want=%h", {RspVal, Err, ReaDat}, {2'b10, 32'h0000_6000});
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick;
    total++;
    if (RspVal !== 1'b0) begin bad++; $display("FAIL rsp_retire got=%b want=0", RspVal); end
  endtask

  task automatic test_byte_en;
    drive(1'b1, 1'b1, 32'h20, 32'hAABB_CCDD, 4'hF); tick;
    drive(1'b1, 1'b1, 32'h20, 32'h1122_3344, 4'h5); tick;
    drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0); tick;
    total++;
    if ({RspVal, Err, ReaDat} !== {2'b10, 32'hAA22_CC44}) begin
      bad++; $display("FAIL byte_en_merge got=%h want=%h", {RspVal, Err, ReaDat}, {2'b10, 32'hAA22_CC44});
    end
    drive(1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0); tick;
    total++;
    if ({RspVal, Err, ReaDat} !== {2'b10, 32'h0}) begin
      bad++; $display("FAIL byte_en_zero_rsp got=%h want=%h", {RspVal, Err, ReaDat}, {2'b10, 32'h0});
    end
    drive(1'b1, 1'b0, 32'h20, 32'h0, 4'hF); tick;
    total++;
    if ({RspVal, Err, ReaDat} !== {2'b10, 32'hAA22_CC44}) begin
      bad++; $display("FAIL byte_en_zero_keep got=%h want=%h", {RspVal, Err, ReaDat}, {2'b10, 32'hAA22_CC44});
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); tick;
  endtask

  task automatic test_errors;
    drive(1'b1, 1'b1, 32'h0, 32'h1234_5678, 4'hF); tick;
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'hF); tick;
    total++;
    if ({RspVal, Err, ReaDat} !== {2'b11, 32'h0}) begin
      bad++; $display("FAIL err_rd_ffffffff got=%h want=%h", {RspVal, Err, ReaDat}, {2'b11, 32'h0});
    end
    drive(1'b1, 1'b0, 32'h202, 32'h0, 4'hF); tick;
    total++;
    if ({RspVal, Err, ReaDat} !== {2'b11, 32'h0}) begin
      bad++; $display("FAIL err_rd_202 got=%h want=%h", {RspVal, Err, ReaDat}, {2'b11, 32'h0});
    end
    drive(1'b1, 1'b1, 32'h200, 32'hFFFF_FFFF, 4'hF); tick;
    total++;
    if ({RspVal, Err, ReaDat} !== {2'b11, 32'h0}) begin
      bad++; $display("FAIL err_wr_200 got=%h want=%h", {RspVal, Err, ReaDat}, {2'b11, 32'h0});
    end
    drive(1'b1, 1'b1, 32'h1, 32'hFFFF_FFFF, 4'hF); tick;
    total++;
    if ({RspVal, Err} !== 2'b11) begin bad++; $display("FAIL err_wr_misaligned got=%b want=11", {RspVal, Err}); end
    drive(1'b1, 1'b0, 32'h1FC, 32'h0, 4'h0); tick;
    total++;
    if ({RspVal, Err} !== 2'b10) begin bad++; $display("FAIL last_index_ok got=%b want=10", {RspVal, Err}); end
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0); tick;
    total++;
    if ({RspVal, Err, ReaDat} !== {2'b10, 32'h1234_5678}) begin
      bad++; $display("FAIL err_no_alias got=%h want=%h", {RspVal, Err, ReaDat}, {2'b10, 32'h1234_5678});
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); tick;
  endtask

  task automatic test_backpressure;
    drive(1'b1, 1'b1, 32'h10, 32'hCAFE_F00D, 4'hF); tick;
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0); tick;
    RspRdy = 1'b0;
    drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    total++;
    if (ReqRdy !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b want=0", ReqRdy); end
    repeat (3) begin
      tick;
      total++;
      if ({RspVal, Err, ReaDat, ReqRdy} !== {2'b10, 32'hCAFE_F00D, 1'b0}) begin
        bad++; $display("FAIL stall_hold got=%h want=%h", {RspVal, Err, ReaDat, ReqRdy}, {2'b10, 32'hCAFE_F00D, 1'b0});
      end
    end
    RspRdy = 1'b1;
    #1;
    total++;
    if (ReqRdy !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%b want=1", ReqRdy); end
    tick;
    total++;
    if ({RspVal, Err, ReaDat} !== {2'b10, 32'hAA22_CC44}) begin
      bad++; $display("FAIL stall_next_rsp got=%h want=%h", {RspVal, Err, ReaDat}, {2'b10, 32'hAA22_CC44});
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); tick;
    total++;
    if (RspVal !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b want=0", RspVal); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [3];
    vals[0] = 32'h0101_0101; vals[1] = 32'h2222_0202; vals[2] = 32'h3030_3333;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'(4 * i), vals[i], 4'hF); tick;
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'(4 * i), 32'h0, 4'h0); tick;
      total++;
      if ({RspVal, Err, ReaDat} !== {2'b10, vals[i]}) begin
        bad++; $display("FAIL b2b_rd%0d got=%h want=%h", i, {RspVal, Err, ReaDat}, {2'b10, vals[i]});
      end
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); tick;
  endtask

  task automatic test_reset_midrun;
    int n;
    drive(1'b1, 1'b1, 32'h7C, 32'h5, 4'hF); tick;
    drive(1'b1, 1'b0, 32'h4, 32'h0, 4'h0); tick;
    RspRdy = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); tick;
    total++;
    if (RspVal !== 1'b1) begin bad++; $display("FAIL midrun_pending got=%b want=1", RspVal); end
    Rst = 1'b1;
    #1;
    total++;
    if ({RspVal, Err, ReaDat, ReqRdy} !== 35'h0) begin
      bad++; $display("FAIL midrun_async_clear got=%h want=0", {RspVal, Err, ReaDat, ReqRdy});
    end
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    tick;
    total++;
    if ({RspVal, ReqRdy} !== 2'b00) begin bad++; $display("FAIL midrun_in_reset got=%b want=00", {RspVal, ReqRdy}); end
    Rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    n = 0;
    while (ReqRdy !== 1'b1 && n < 400) begin tick; n++; end
    total++;
    if (n !== CLR_CYC) begin bad++; $display("FAIL midrun_ready_delay got=%0d want=%0d", n, CLR_CYC); end
    total++;
    if (RspVal !== 1'b0) begin bad++; $display("FAIL midrun_discard got=%b want=0", RspVal); end
    RspRdy = 1'b1;
    drive(1'b1, 1'b0, 32'h7C, 32'h0, 4'h0); tick;
    total++;
    if ({RspVal, Err, ReaDat} !== {2'b10, EXP_7C}) begin
      bad++; $display("FAIL midrun_mem_7c got=%h want=%h", {RspVal, Err, ReaDat}, {2'b10, EXP_7C});
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); tick;
  endtask

  task automatic test_random;
    logic [31:0] mdat [128];
    logic [3:0]  mknown [128];
    rsp_t        q [$];
    rsp_t        e;
    logic        exp_rdy;
    logic        aerr;
    logic [31:0] a;
    int          sel;
    int          idx;
    for (int i = 0; i < 128; i++) begin mdat[i] = 32'h0; mknown[i] = 4'h0; end
    for (int c = 0; c < 400; c++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       a = 32'($urandom_range(0, 15) * 4);
      else if (sel < 8)  a = 32'($urandom_range(0, 127) * 4);
      else if (sel == 8) a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else               a = $urandom;
      ReqVal = ($urandom_range(0, 3) != 0);
      WE2    = 1'($urandom_range(0, 1));
      Addr   = a;
      WriDat = $urandom;
      ByteEn = 4'($urandom_range(0, 15));
      RspRdy = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = !(q.size() != 0 && !RspRdy);
      total++;
      if (ReqRdy !== exp_rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", c, ReqRdy, exp_rdy); end
      total++;
      if (RspVal !== (q.size() != 0)) begin bad++; $display("FAIL rnd_rspval cyc=%0d got=%b want=%b", c, RspVal, q.size() != 0); end
      if (q.size() != 0) begin
        total++;
        if (Err !== q[0].err || (ReaDat & q[0].mask) !== q[0].dat) begin
          bad++; $display("FAIL rnd_rsp cyc=%0d got=%b/%h want=%b/%h", c, Err, ReaDat & q[0].mask, q[0].err, q[0].dat);
        end
        if (RspRdy) void'(q.pop_front());
      end
      if (ReqVal && exp_rdy) begin
        aerr = (a[1:0] != 2'b00) || ((a >> 2) >= 32'd128);
        idx  = int'(a >> 2);
        e.err = aerr; e.dat = 32'h0; e.mask = 32'hFFFF_FFFF;
        if (!aerr && !WE2) begin
          for (int b = 0; b < 4; b++) e.mask[8*b +: 8] = {8{mknown[idx][b]}};
          e.dat = mdat[idx] & e.mask;
        end
        if (!aerr && WE2) begin
          for (int b = 0; b < 4; b++) begin
            if (ByteEn[b]) begin mdat[idx][8*b +: 8] = WriDat[8*b +: 8]; mknown[idx][b] = 1'b1; end
          end
        end
        q.push_back(e);
      end
      @(posedge Clk);
      #1;
    end
    RspRdy = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); tick;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_write_read;
    test_byte_en;
    test_errors;
    test_backpressure;
    test_back_to_back;
    test_reset_midrun;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, meaning byte-address width.
REQ-002 SHALL have parameter DWIDTH, default 32, meaning data word width; a multiple of 8 and at least 8.
REQ-003 SHALL have parameter ALENGTH, default 128, meaning number of words stored.
REQ-004 SHALL have port Clk, input, 1, meaning the single clock; every state changes on its rising edge.
REQ-005 SHALL have port Rst, input, 1, meaning reset; asynchronous and active-high.
REQ-006 SHALL have port ReqVal, input, 1, meaning a request is presented.
REQ-007 SHALL have port ReqRdy, output, 1, meaning the block can accept a request this cycle.
REQ-008 SHALL have port WE2, input, 1, meaning write (1) or read (0) for the request.
REQ-009 SHALL have port Addr, input, AWIDTH, meaning the request byte address.
REQ-010 SHALL have port WriDat, input, DWIDTH, meaning the write data.
REQ-011 SHALL have port ByteEn, input, DWIDTH/8, meaning per-byte write strobes; bit i covers WriDat[8i+7:8i].
REQ-012 SHALL have port RspVal, output, 1, meaning a response is presented.
REQ-013 SHALL have port RspRdy, input, 1, meaning the consumer takes the response this cycle.
REQ-014 SHALL have port ReaDat, output, DWIDTH, meaning read data for the response.
REQ-015 SHALL have port Err, output, 1, meaning the response is an error; valid only while RspVal=1.

Function
REQ-016 A request SHALL be accepted on a rising edge where ReqVal=1 and ReqRdy=1.
REQ-017 ReqRdy SHALL be 1 iff the state is RUN and NOT (RspVal=1 and RspRdy=0); this combinational path gives one request per cycle throughput.
REQ-018 Word index SHALL be Addr >> log2(DWIDTH/8); a request is in error if any low log2(DWIDTH/8) Addr bits are nonzero (misaligned) or the index is >= ALENGTH (out of range).
REQ-019 An accepted error-free write SHALL update only the bytes whose ByteEn bit is 1, at the accepting edge; a write with ByteEn=0 changes nothing and still gets a response.
REQ-020 An accepted read SHALL present the word in the response one cycle after acceptance (latency 1); ByteEn is ignored on reads.
REQ-021 Every accepted request SHALL produce exactly one response on the next edge: RspVal=1, Err per REQ-018, ReaDat = word for error-free reads, else 0.
REQ-022 An erroneous write SHALL leave memory unchanged.
REQ-023 A response SHALL hold RspVal, Err and ReaDat stable until an edge with RspRdy=1; at that edge RspVal falls unless a new request is accepted at the same edge.
REQ-024 A read accepted the cycle after a write to the same word SHALL return the newly written bytes.
REQ-025 The state machine SHALL have states CLEAR and RUN; CLEAR exists only per REQ-030.

Reset
REQ-026 While Rst=1: RspVal=0, Err=0, ReaDat=0 and ReqRdy=0, regardless of Clk.
REQ-027 Assertion of Rst during operation SHALL discard any pending response; no response for it is produced after Rst falls.
REQ-028 After Rst falls, the state SHALL be CLEAR when DATMEM_INIT_CLEAR_EN is defined, else RUN.
REQ-029 Without DATMEM_INIT_CLEAR_EN, Rst SHALL NOT alter memory contents.

Configuration
REQ-030 With macro DATMEM_INIT_CLEAR_EN defined: CLEAR writes 0 to one word per cycle, indices 0..ALENGTH-1, using a counter reset to 0; after the write to index ALENGTH-1 the state moves to RUN; ReqRdy=0 throughout CLEAR; the first request can be accepted ALENGTH cycles after Rst falls.
REQ-031 Without DATMEM_INIT_CLEAR_EN: no clear counter and no CLEAR state; ReqRdy may be 1 on the first edge after Rst falls; unwritten words read as undefined.
REQ-032 Rst asserted during CLEAR SHALL restart the sweep at index 0.

Verification
REQ-033 Write Addr=0x10, WriDat=0x00006000, ByteEn=0xF, then read Addr=0x10 -> read response one cycle after acceptance, ReaDat=0x00006000, Err=0.
REQ-034 Write 0xAABBCCDD to 0x20, then write 0x11223344 to 0x20 with ByteEn=0x5, then read 0x20 -> ReaDat=0xAA22CC44.
REQ-035 Read Addr=0xFFFFFFFF, then Addr=0x00000202 (index 128) -> both responses Err=1, ReaDat=0; a following write to 0x200 with Err leaves word 0 unchanged.
REQ-036 Hold RspRdy=0 for 3 cycles with a read response pending -> ReqRdy=0 and response stable for those 3 cycles; RspRdy=1 -> response retires, ReqRdy=1.
REQ-037 Back-to-back reads of 0x0,0x4,0x8 with RspRdy=1 -> three consecutive cycles with RspVal=1 and data in order.
REQ-038 With DATMEM_INIT_CLEAR_EN: write 0x5 to 0x7C, pulse Rst, read 0x7C after ReqRdy rises -> ReqRdy rises exactly 128 cycles after Rst falls, ReaDat=0.
